// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - pipelined bitwise logic unit with elastic valid/ready stages
//
// Computes one of eight bitwise operations on A/B and derives ZERO/ONES/PARITY
// from the result in the same cycle. Result and flags then travel together
// through STAGES elastic register stages.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   in_valid   in   A/B/OP valid this cycle
//   in_ready   out  unit accepts input this cycle (combinational)
//   A, B       in   N_BITS operands
//   OP         in   3-bit operation select
//   out_valid  out  C/flags valid
//   out_ready  in   consumer accepts output
//   C          out  N_BITS result
//   ZERO       out  C == 0
//   ONES       out  C == all ones
//   PARITY     out  XOR-reduction of C

module logic_unit_pipe #(
    parameter int N_BITS = 8,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS-1:0] A,
    input  logic [N_BITS-1:0] B,
    input  logic [2:0]        OP,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_BITS-1:0] C,
    output logic              ZERO,
    output logic              ONES,
    output logic              PARITY
);

    if (N_BITS < 1) begin : g_bad_width
        $error("logic_unit_pipe: N_BITS must be >= 1");
    end

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("logic_unit_pipe: STAGES must be in 1..4");
    end

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_ANDN = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    // Stage payload layout: {result, zero, ones, parity}
    localparam int W = N_BITS + 3;

    logic [N_BITS-1:0] result;
    logic [W-1:0]      stage_in;

    always_comb begin
        result = '0;
        case (OP)
            OP_AND:  result = A & B;
            OP_OR:   result = A | B;
            OP_XOR:  result = A ^ B;
            OP_NAND: result = ~(A & B);
            OP_NOR:  result = ~(A | B);
            OP_XNOR: result = ~(A ^ B);
            OP_ANDN: result = A & ~B;
            OP_PASS: result = A;
            default: result = '0;
        endcase
    end

    assign stage_in = {result, ~|result, &result, ^result};

    // One generate block per stage. Each stage sees the valid/data of the
    // stage before it (stage 0 sees the unit inputs) and the ready of the
    // stage after it (the last stage sees out_ready). A stage is ready, and
    // therefore loads, whenever it is empty or its successor is ready, so
    // bubbles collapse even while the consumer is stalled.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic         v_q;
        logic         v_d;
        logic [W-1:0] data_q;
        logic [W-1:0] data_d;
        logic         prev_v;
        logic [W-1:0] prev_data;
        logic         next_rdy;
        logic         rdy;

        if (k == 0) begin : g_src
            assign prev_v    = in_valid;
            assign prev_data = stage_in;
        end else begin : g_src
            assign prev_v    = g_stage[k-1].v_q;
            assign prev_data = g_stage[k-1].data_q;
        end

        if (k == STAGES - 1) begin : g_sink
            assign next_rdy = out_ready;
        end else begin : g_sink
            assign next_rdy = g_stage[k+1].rdy;
        end

        assign rdy = ~v_q | next_rdy;

        always_comb begin
            v_d    = v_q;
            data_d = data_q;
            if (rdy) begin
                v_d = prev_v;
                // Data only moves with a valid item, so an empty stage
                // passing through keeps the last payload it held.
                if (prev_v) begin
                    data_d = prev_data;
                end
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                v_q    <= 1'b0;
                data_q <= '0;
            end else begin
                v_q    <= v_d;
                data_q <= data_d;
            end
        end
    end

    assign in_ready  = g_stage[0].rdy;
    assign out_valid = g_stage[STAGES-1].v_q;
    assign {C, ZERO, ONES, PARITY} = g_stage[STAGES-1].data_q;

endmodule
